// File: rtl/midi_pkg.sv
// Shared types and constants for the MIDI note decoder: parser states,
// status nibbles and the note-to-playback-period table.
package midi_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_D1 = 2'd1,
        WAIT_D2 = 2'd2,
        SKIP    = 2'd3
    } state_e;

    localparam logic [3:0] NOTE_OFF = 4'h8;
    localparam logic [3:0] NOTE_ON  = 4'h9;

    localparam int NOTE_CW = 24;
    typedef logic [NOTE_CW-1:0] period_t;
    typedef period_t [0:127] note_cycles_t;

    // Periods for octave -1 (C-1..B-1) at 100 MHz with 256 samples per cycle;
    // each higher octave halves the period.
    localparam period_t [0:11] OCTAVE_BASE = {
        24'd47778, 24'd45096, 24'd42566, 24'd40177, 24'd37922, 24'd35793,
        24'd33784, 24'd31888, 24'd30098, 24'd28409, 24'd26815, 24'd25310
    };

    function automatic note_cycles_t build_note_cycles();
        note_cycles_t t;
        for (int i = 0; i < 128; i++) begin
            t[i] = OCTAVE_BASE[i % 12] >> (i / 12);
        end
        return t;
    endfunction

    localparam note_cycles_t NOTE_CYCLES = build_note_cycles();

    // CHANNEL == 16 means omni: every channel nibble matches.
    function automatic logic channel_match(input logic [3:0] n, input int channel);
        return (channel == 16) || (32'(n) == channel);
    endfunction

endpackage

// File: rtl/midi_note_decoder_if.sv
// Byte input and note-event output bundle of the MIDI note decoder.
interface midi_note_decoder_if #(
    parameter int CW = 24
);
    logic [7:0]    byte_in;
    logic          byte_valid_in;
    logic          valid_out;
    logic          is_note_on;
    logic [6:0]    note_out;
    logic [6:0]    velocity_out;
    logic [CW-1:0] cycles_between_samples;
    logic [7:0]    dropped_count;

    modport master (
        output byte_in, byte_valid_in,
        input  valid_out, is_note_on, note_out, velocity_out,
               cycles_between_samples, dropped_count
    );

    modport slave (
        input  byte_in, byte_valid_in,
        output valid_out, is_note_on, note_out, velocity_out,
               cycles_between_samples, dropped_count
    );
endinterface

// File: rtl/midi_note_decoder_note_period_lut.sv
// Registered note-number to playback-period lookup; the result is loaded
// only when a note event completes and holds until the next one.
module note_period_lut
    import midi_pkg::*;
#(
    parameter int CW = 24
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          en_i,
    input  logic [6:0]    note_i,
    output logic [CW-1:0] period_o
);
    logic [CW-1:0] period_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            period_q <= '0;
        end else if (en_i) begin
            period_q <= CW'(NOTE_CYCLES[note_i]);
        end
    end

    assign period_o = period_q;
endmodule

// File: rtl/midi_note_decoder.sv
// MIDI byte-stream parser that extracts note-on/off events for one channel
// (or all channels) with running status and realtime-byte transparency.
module midi_note_decoder
    import midi_pkg::*;
#(
    parameter int CHANNEL = 0,
    parameter int CW      = 24
) (
    input logic                 clk_in,
    input logic                 rst_in,
    midi_note_decoder_if.slave  bus
);
    state_e      state_q, state_d;
    logic [7:0]  run_status_q, run_status_d;
    logic [6:0]  note_q, note_d;
    logic [7:0]  dropped_q, dropped_d;
    logic        valid_q;
    logic        is_on_q;
    logic [6:0]  note_out_q;
    logic [6:0]  vel_q;
    logic        fire_c;
    logic        drop_c;
    logic        realtime_c;
    logic [CW-1:0] period_w;

    assign realtime_c = (bus.byte_in[7:3] == 5'b11111);

    always_comb begin
        state_d      = state_q;
        run_status_d = run_status_q;
        note_d       = note_q;
        fire_c       = 1'b0;
        drop_c       = 1'b0;
        if (bus.byte_valid_in && !realtime_c) begin
            if (bus.byte_in[7]) begin
                // Any status abandons a partial message; only note messages
                // on our channel re-arm running status.
                if ((bus.byte_in[7:4] == NOTE_ON || bus.byte_in[7:4] == NOTE_OFF) &&
                    channel_match(bus.byte_in[3:0], CHANNEL)) begin
                    run_status_d = bus.byte_in;
                    state_d      = WAIT_D1;
                end else begin
                    run_status_d = 8'h00;
                    state_d      = SKIP;
                end
            end else begin
                case (state_q)
                    WAIT_D1: begin
                        note_d  = bus.byte_in[6:0];
                        state_d = WAIT_D2;
                    end
                    WAIT_D2: begin
                        fire_c  = 1'b1;
                        state_d = WAIT_D1;
                    end
                    default: drop_c = 1'b1;
                endcase
            end
        end
    end

    always_comb begin
        dropped_d = dropped_q;
        if (drop_c && dropped_q != 8'hFF) begin
            dropped_d = dropped_q + 8'd1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= IDLE;
            run_status_q <= 8'h00;
            note_q       <= 7'd0;
            dropped_q    <= 8'd0;
            valid_q      <= 1'b0;
            is_on_q      <= 1'b0;
            note_out_q   <= 7'd0;
            vel_q        <= 7'd0;
        end else begin
            state_q      <= state_d;
            run_status_q <= run_status_d;
            note_q       <= note_d;
            dropped_q    <= dropped_d;
            valid_q      <= fire_c;
            if (fire_c) begin
                // Note-on with velocity 0 is a note-off by MIDI convention.
                is_on_q    <= (run_status_q[7:4] == NOTE_ON) && (bus.byte_in[6:0] != 7'd0);
                note_out_q <= note_q;
                vel_q      <= bus.byte_in[6:0];
            end
        end
    end

    note_period_lut #(.CW(CW)) u_lut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .en_i     (fire_c),
        .note_i   (note_q),
        .period_o (period_w)
    );

    // These feed the oscillator coordinator directly (isNoteOn, valid_in,
    // cycles_between_samples).
    assign bus.valid_out              = valid_q;
    assign bus.is_note_on             = is_on_q;
    assign bus.note_out               = note_out_q;
    assign bus.velocity_out           = vel_q;
    assign bus.cycles_between_samples = period_w;
    assign bus.dropped_count          = dropped_q;
endmodule
